// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite mover: FSM state encoding, RGB444
// colour constants and the sprite bitmap generator used by the ROM.
package sprite_pkg;

   // Debug-visible FSM encoding; the order matches the operation flow.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ERASE = 2'd1,
      S_DRAW  = 2'd2,
      S_DONE  = 2'd3
   } sprite_state_t;

   // RGB444 colour constants.
   localparam logic [11:0] RGB_BLACK = 12'h000;
   localparam logic [11:0] RGB_WHITE = 12'hFFF;
   localparam logic [11:0] RGB_RED   = 12'hF00;
   localparam logic [11:0] RGB_GREEN = 12'h0F0;
   localparam logic [11:0] RGB_BLUE  = 12'h00F;

   // Sprite bitmap: entry 0 is black (the transparent key by default).
   // Every other entry is non-black, so erase and draw pixels can be told apart.
   function automatic logic [31:0] rom_pattern(input logic [31:0] addr);
      return (addr * 32'h0000_0123) & 32'h0000_0FFF;
   endfunction

endpackage

// File: rtl/sprite_mover_if.sv
// Command/pixel bundle between a game-control FSM (master) and the sprite
// mover (slave), plus the framebuffer write port driven by the mover.
//
// Handshake: start/load are single-cycle requests that are only honoured
// while busy is low. A start is accepted on the clock edge where it is
// sampled with busy low and load low; busy rises on that same edge and
// falls when the operation returns to idle, when done pulses for one cycle.
// Requests that arrive while busy is high are dropped, never queued. load
// takes priority over start when both are presented together.
interface sprite_mover_if
   import sprite_pkg::*;
#(
   parameter int X_W   = 8,
   parameter int Y_W   = 7,
   parameter int COL_W = 12,
   parameter int D_W   = 4
);
   logic             start;
   logic             erase_en;
   logic [D_W-1:0]   dx;
   logic [D_W-1:0]   dy;
   logic             load;
   logic [X_W-1:0]   load_x;
   logic [Y_W-1:0]   load_y;
   logic             busy;
   logic             done;
   logic             plot;
   logic [X_W-1:0]   x_out;
   logic [Y_W-1:0]   y_out;
   logic [COL_W-1:0] colour_out;
   logic [X_W-1:0]   pos_x;
   logic [Y_W-1:0]   pos_y;
   sprite_state_t    state;

   modport master (
      output start, erase_en, dx, dy, load, load_x, load_y,
      input  busy, done, plot, x_out, y_out, colour_out, pos_x, pos_y, state
   );

   modport slave (
      input  start, erase_en, dx, dy, load, load_x, load_y,
      output busy, done, plot, x_out, y_out, colour_out, pos_x, pos_y, state
   );
endinterface

// File: rtl/sprite_rom.sv
// Sprite bitmap ROM: combinational read, one colour per pixel, row-major
// (x fastest). Contents come from the package bitmap generator.
module sprite_rom
   import sprite_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int COL_W = 12,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0]    i_addr,
   output logic [COL_W-1:0] o_data
);
   // Pure lookup: the address selects one bitmap entry.
   assign o_data = COL_W'(rom_pattern(32'(i_addr)));
endmodule

// File: rtl/sprite_mover.sv
// Sprite mover top: keeps one sprite's position and, per move command,
// erases the old footprint and redraws at the clamped new position, one
// pixel per clock on the framebuffer write port.
// Optional feature macro: SPRITE_TRANSPARENT_EN (DRAW pixels whose ROM
// colour equals KEY_COLOUR are not plotted; timing is unchanged).
// SPR_W and SPR_H must be powers of two and at least 2.
module sprite_mover
   import sprite_pkg::*;
#(
   parameter int SPR_W      = 16,
   parameter int SPR_H      = 4,
   parameter int X_W        = 8,
   parameter int Y_W        = 7,
   parameter int COL_W      = 12,
   parameter int D_W        = 4,
   parameter int SCREEN_W   = 160,
   parameter int SCREEN_H   = 120,
   parameter int INIT_X     = 72,
   parameter int INIT_Y     = 56,
   parameter int BG_COLOUR  = 0,
   parameter int KEY_COLOUR = 0
) (
   input  logic          clk,
   input  logic          reset,
   sprite_mover_if.slave bus
);
   localparam int NPIX  = SPR_W * SPR_H;
   localparam int PTR_W = $clog2(NPIX);
   localparam int PX_W  = $clog2(SPR_W);
   localparam int PY_W  = PTR_W - PX_W;

   // Clamp limits, held in the widened signed domain used for the sums.
   localparam logic signed [X_W+1:0] MAX_X = (X_W+2)'(SCREEN_W - SPR_W);
   localparam logic signed [Y_W+1:0] MAX_Y = (Y_W+2)'(SCREEN_H - SPR_H);

`ifdef SPRITE_TRANSPARENT_EN
   localparam bit TRANSPARENT = 1'b1;
`else
   localparam bit TRANSPARENT = 1'b0;
`endif

   // Two guard bits keep position+delta free of overflow for any position.
   function automatic logic [X_W-1:0] clamp_x(input logic signed [X_W+1:0] v);
      if (v[X_W+1])     return '0;
      else if (v > MAX_X) return MAX_X[X_W-1:0];
      else              return v[X_W-1:0];
   endfunction

   function automatic logic [Y_W-1:0] clamp_y(input logic signed [Y_W+1:0] v);
      if (v[Y_W+1])     return '0;
      else if (v > MAX_Y) return MAX_Y[Y_W-1:0];
      else              return v[Y_W-1:0];
   endfunction

   sprite_state_t    r_state;
   logic [PTR_W-1:0] r_ptr;
   logic [X_W-1:0]   r_pos_x;
   logic [Y_W-1:0]   r_pos_y;
   logic [X_W-1:0]   r_nx;
   logic [Y_W-1:0]   r_ny;
   logic             r_busy;
   logic             r_done;
   logic             r_plot;
   logic [X_W-1:0]   r_x;
   logic [Y_W-1:0]   r_y;
   logic [COL_W-1:0] r_col;

   sprite_state_t         w_state_nxt;
   logic                  w_plot_nxt;
   logic [X_W-1:0]        w_x_nxt;
   logic [Y_W-1:0]        w_y_nxt;
   logic [COL_W-1:0]      w_col_nxt;
   logic [PX_W-1:0]       w_px;
   logic [PY_W-1:0]       w_py;
   logic                  w_ptr_last;
   logic [COL_W-1:0]      w_rom_data;
   logic                  w_draw_vis;
   logic                  w_accept;
   logic                  w_load_ok;
   logic signed [X_W+1:0] w_sum_x;
   logic signed [Y_W+1:0] w_sum_y;
   logic signed [X_W+1:0] w_load_sx;
   logic signed [Y_W+1:0] w_load_sy;

   sprite_rom #(
      .DEPTH (NPIX),
      .COL_W (COL_W),
      .AW    (PTR_W)
   ) u_rom (
      .i_addr (r_ptr),
      .o_data (w_rom_data)
   );

   assign w_px       = r_ptr[PX_W-1:0];
   assign w_py       = r_ptr[PTR_W-1:PX_W];
   assign w_ptr_last = (r_ptr == PTR_W'(NPIX - 1));
   assign w_draw_vis = !(TRANSPARENT && (w_rom_data == COL_W'(KEY_COLOUR)));

   // load is only honoured in idle and shadows a simultaneous start.
   assign w_load_ok = (r_state == S_IDLE) && bus.load;
   assign w_accept  = (r_state == S_IDLE) && bus.start && !bus.load;

   assign w_sum_x   = $signed({2'b00, r_pos_x}) + $signed({{(X_W+2-D_W){bus.dx[D_W-1]}}, bus.dx});
   assign w_sum_y   = $signed({2'b00, r_pos_y}) + $signed({{(Y_W+2-D_W){bus.dy[D_W-1]}}, bus.dy});
   assign w_load_sx = $signed({2'b00, bus.load_x});
   assign w_load_sy = $signed({2'b00, bus.load_y});

   // Next state and next pixel-port values, derived from the current state and pointer.
   always_comb begin
      w_state_nxt = r_state;
      w_plot_nxt  = 1'b0;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_col_nxt   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = bus.erase_en ? S_ERASE : S_DRAW;
         end
         S_ERASE: begin
            w_plot_nxt = 1'b1;
            w_x_nxt    = r_pos_x + X_W'(w_px);
            w_y_nxt    = r_pos_y + Y_W'(w_py);
            w_col_nxt  = COL_W'(BG_COLOUR);
            if (w_ptr_last) w_state_nxt = S_DRAW;
         end
         S_DRAW: begin
            w_plot_nxt = w_draw_vis;
            w_x_nxt    = r_nx + X_W'(w_px);
            w_y_nxt    = r_ny + Y_W'(w_py);
            w_col_nxt  = w_rom_data;
            if (w_ptr_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register; reset aborts any operation on the spot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Datapath registers: pointer, positions, target and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr   <= '0;
         r_pos_x <= X_W'(INIT_X);
         r_pos_y <= Y_W'(INIT_Y);
         r_nx    <= '0;
         r_ny    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_plot  <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_col   <= '0;
      end else begin
         r_busy <= (w_state_nxt != S_IDLE);
         r_done <= (r_state == S_DONE);
         r_plot <= w_plot_nxt;
         r_x    <= w_x_nxt;
         r_y    <= w_y_nxt;
         r_col  <= w_col_nxt;
         // The pointer wraps to 0 on its own at the end of each phase.
         if ((r_state == S_ERASE) || (r_state == S_DRAW)) r_ptr <= r_ptr + PTR_W'(1);
         if (w_accept) begin
            r_nx <= clamp_x(w_sum_x);
            r_ny <= clamp_y(w_sum_y);
         end
         if (w_load_ok) begin
            r_pos_x <= clamp_x(w_load_sx);
            r_pos_y <= clamp_y(w_load_sy);
         end else if (r_state == S_DONE) begin
            r_pos_x <= r_nx;
            r_pos_y <= r_ny;
         end
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.plot       = r_plot;
   assign bus.x_out      = r_x;
   assign bus.y_out      = r_y;
   assign bus.colour_out = r_col;
   assign bus.pos_x      = r_pos_x;
   assign bus.pos_y      = r_pos_y;
   assign bus.state      = r_state;

endmodule
